// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - response fault codes
//   - FSM state encoding
//   - helpers for byte-enable and store-lane generation
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } lsu_state_e;

  // Size is carried in funct3[1:0] for both signed and unsigned variants.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << a;
      2'b01:   byte_en = 4'b0011 << a;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the store data across all lanes so the byte enables alone
  // select where it lands.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension (purely combinational).
//   rdata   : raw 32-bit word from memory
//   addr_lo : byte offset within the word
//   funct3  : load type (B/H/W/BU/HU)
//   data    : right-aligned, sign/zero-extended result (0 for unused codes)
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0]        shifted;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;
  logic signed [31:0] b_ext;
  logic signed [31:0] h_ext;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    b_s     = shifted[7:0];
    h_s     = shifted[15:0];
    b_ext   = b_s;
    h_ext   = h_s;
    data    = '0;
    case (funct3)
      F3_B:    data = b_ext;
      F3_H:    data = h_ext;
      F3_W:    data = shifted;
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns an ALU effective address + rs2 + funct3 into a single
// outstanding request/ready data-memory access and returns extended load data
// or a fault to writeback.
//   req_*  : request from execute (req_ready high only when idle)
//   mem_*  : registered data-memory port, fields stable while mem_valid
//   rsp_*  : registered one-cycle response (data, fault code, tag, trap addr)
// TIMEOUT_CYCLES bounds how long mem_valid may wait for mem_ready (0 = never).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  input  logic        req_is_store,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic        rsp_is_load,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_fault,
  output logic [31:0] rsp_addr
);

  lsu_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        store_q, store_d;
  logic [4:0]  rd_q, rd_d;

  logic        mem_valid_q, mem_valid_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_is_load_q, rsp_is_load_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;

  logic        req_illegal;
  logic        req_misalign;
  logic [31:0] load_val;

  load_align u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (load_val)
  );

  always_comb begin
    // Stores have no unsigned variants, so any funct3[2] store is illegal.
    req_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) || (req_is_store && req_funct3[2]);
    req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    f3_d          = f3_q;
    store_d       = store_q;
    rd_d          = rd_q;
    mem_valid_d   = mem_valid_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    rsp_valid_d   = 1'b0;
    rsp_is_load_d = rsp_is_load_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_data_d    = rsp_data_q;
    rsp_fault_d   = rsp_fault_q;
    rsp_addr_d    = rsp_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_illegal || req_misalign) begin
            rsp_valid_d   = 1'b1;
            rsp_fault_d   = req_illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
            rsp_data_d    = '0;
            rsp_rd_d      = req_rd;
            rsp_addr_d    = req_addr;
            rsp_is_load_d = !req_is_store;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = '0;
            addr_d      = req_addr;
            f3_d        = req_funct3;
            store_d     = req_is_store;
            rd_d        = req_rd;
            mem_valid_d = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = store_lanes(req_funct3, req_wdata);
            mem_be_d    = byte_en(req_funct3, req_addr[1:0]);
          end
        end
      end
      ST_ACCESS: begin
        // mem_ready is tested first so a ready in the expiring cycle still completes.
        if (mem_ready || ((TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1))) begin
          state_d       = ST_IDLE;
          mem_valid_d   = 1'b0;
          mem_we_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_fault_d   = mem_ready ? FAULT_NONE : FAULT_TIMEOUT;
          rsp_data_d    = (mem_ready && !store_q) ? load_val : 32'd0;
          rsp_rd_d      = rd_q;
          rsp_addr_d    = addr_q;
          rsp_is_load_d = !store_q;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      f3_q          <= '0;
      store_q       <= 1'b0;
      rd_q          <= '0;
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_is_load_q <= 1'b0;
      rsp_rd_q      <= '0;
      rsp_data_q    <= '0;
      rsp_fault_q   <= '0;
      rsp_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      f3_q          <= f3_d;
      store_q       <= store_d;
      rd_q          <= rd_d;
      mem_valid_q   <= mem_valid_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_is_load_q <= rsp_is_load_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_data_q    <= rsp_data_d;
      rsp_fault_q   <= rsp_fault_d;
      rsp_addr_q    <= rsp_addr_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign mem_valid   = mem_valid_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_is_load = rsp_is_load_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_fault   = rsp_fault_q;
  assign rsp_addr    = rsp_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios followed by randomized
// requests, each checked against a byte-level reference model.
module tb_load_store_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_is_store;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_is_load;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_fault;
  logic [31:0] rsp_addr;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_funct3   (req_funct3),
    .req_is_store (req_is_store),
    .req_rd       (req_rd),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_is_load  (rsp_is_load),
    .rsp_rd       (rsp_rd),
    .rsp_data     (rsp_data),
    .rsp_fault    (rsp_fault),
    .rsp_addr     (rsp_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---- reference model ----
  function automatic int acc_size(input logic [2:0] f3);
    int s;
    s = int'(f3) % 4;
    if (s == 0) return 1;
    if (s == 1) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] m_fault(input logic [2:0] f3, input logic st, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7 || (st && f3 >= 4)) return 2'd2;
    if ((a % acc_size(f3)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = acc_size(f3);
    int v  = ((1 << sz) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int sz = acc_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int sz = acc_size(f3);
    v = longint'(rd) >> (8 * (a % 4));
    if (sz == 1) begin
      v = v % 256;
      if (f3 < 4 && v >= 128) v = v - 256;
    end else if (sz == 2) begin
      v = v % 65536;
      if (f3 < 4 && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  // One complete request. ready_at = edge (counted from the accept edge) at
  // which mem_ready is high; values above the timeout mean never.
  task automatic run_req(input string nm, input logic [31:0] a, input logic [2:0] f3,
                         input logic st, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] rdata, input int ready_at);
    logic [1:0] ef;
    int resp_edge, mv_cycles, unstable, exp_edge;
    ef = m_fault(f3, st, a);
    @(negedge clk);
    req_addr = a; req_funct3 = f3; req_is_store = st; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    chk({nm, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ef != 2'd0) begin
      chk({nm, "_flt_memvalid"}, {31'd0, mem_valid}, 32'd0);
      chk({nm, "_flt_rspvalid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_flt_code"}, {30'd0, rsp_fault}, {30'd0, ef});
      chk({nm, "_flt_addr"}, rsp_addr, a);
      chk({nm, "_flt_rd"}, {27'd0, rsp_rd}, {27'd0, rd});
      chk({nm, "_flt_isload"}, {31'd0, rsp_is_load}, {31'd0, !st});
      chk({nm, "_flt_data"}, rsp_data, 32'd0);
      @(posedge clk); #1;
      chk({nm, "_flt_pulse"}, {31'd0, rsp_valid}, 32'd0);
      return;
    end
    chk({nm, "_memvalid"}, {31'd0, mem_valid}, 32'd1);
    chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, st});
    chk({nm, "_maddr"}, mem_addr, a & 32'hFFFF_FFFC);
    chk({nm, "_be"}, {28'd0, mem_be}, {28'd0, m_be(f3, a)});
    if (st) chk({nm, "_wdata"}, mem_wdata, m_wdata(f3, wd));
    chk({nm, "_busy"}, {31'd0, req_ready}, 32'd0);
    resp_edge = -1; mv_cycles = 0; unstable = 0;
    for (int k = 1; k <= 40; k++) begin
      if (mem_valid) mv_cycles++;
      if (mem_addr !== (a & 32'hFFFF_FFFC) || mem_be !== m_be(f3, a)) unstable++;
      mem_ready = (k == ready_at);
      mem_rdata = (k == ready_at) ? rdata : $urandom;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (rsp_valid) begin
        resp_edge = k;
        break;
      end
    end
    exp_edge = (ready_at <= TMO) ? ready_at : TMO;
    chk({nm, "_rsp_edge"}, resp_edge, exp_edge);
    chk({nm, "_mv_cycles"}, mv_cycles, exp_edge);
    chk({nm, "_stable"}, unstable, 0);
    chk({nm, "_memvalid_off"}, {31'd0, mem_valid}, 32'd0);
    chk({nm, "_code"}, {30'd0, rsp_fault}, (ready_at <= TMO) ? 32'd0 : 32'd3);
    chk({nm, "_data"}, rsp_data, (ready_at <= TMO && !st) ? m_load(f3, a, rdata) : 32'd0);
    chk({nm, "_rd"}, {27'd0, rsp_rd}, {27'd0, rd});
    chk({nm, "_addr"}, rsp_addr, a);
    chk({nm, "_isload"}, {31'd0, rsp_is_load}, {31'd0, !st});
    chk({nm, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rf;
    logic        rs;
    int          rw;

    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_funct3 = '0; req_is_store = 1'b0; req_rd = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_memvalid", {31'd0, mem_valid}, 32'd0);
    chk("rst_rspvalid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_rspdata", rsp_data, 32'd0);
    chk("rst_fault", {30'd0, rsp_fault}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed scenarios
    run_req("lb",  32'h0000_1003, 3'b000, 1'b0, 32'd0, 5'd1, 32'h80FF_1234, 1);
    run_req("lhu", 32'h0000_2002, 3'b101, 1'b0, 32'd0, 5'd2, 32'hBEEF_0000, 1);
    run_req("lh",  32'h0000_2002, 3'b001, 1'b0, 32'd0, 5'd3, 32'hBEEF_0000, 2);
    run_req("sb",  32'h0000_3001, 3'b000, 1'b1, 32'h0000_00AB, 5'd4, 32'h1234_5678, 1);
    run_req("sh",  32'h0000_3002, 3'b001, 1'b1, 32'h1234_CDEF, 5'd5, 32'h0, 3);
    run_req("lw_mis", 32'h0000_4002, 3'b010, 1'b0, 32'd0, 5'd6, 32'h0, 1);
    run_req("f3_011", 32'h0000_4000, 3'b011, 1'b0, 32'd0, 5'd7, 32'h0, 1);
    run_req("sbu_ill", 32'h0000_4001, 3'b101, 1'b1, 32'd0, 5'd8, 32'h0, 1);
    run_req("lw_tmo", 32'h0000_5000, 3'b010, 1'b0, 32'd0, 5'd9, 32'h0, 100);
    run_req("lw_last", 32'h0000_5004, 3'b010, 1'b0, 32'd0, 5'd10, 32'hCAFE_F00D, TMO);

    // Reset in the middle of an access
    @(negedge clk);
    req_addr = 32'h0000_6000; req_funct3 = 3'b010; req_is_store = 1'b0; req_rd = 5'd11;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_memvalid", {31'd0, mem_valid}, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_memvalid", {31'd0, mem_valid}, 32'd0);
    chk("mid_rst_rspvalid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_after_rspvalid", {31'd0, rsp_valid}, 32'd0);
    run_req("lw_post_rst", 32'h0000_6004, 3'b010, 1'b0, 32'd0, 5'd12, 32'h0123_4567, 2);

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      rf = 3'($urandom_range(0, 7));
      rs = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(1, 3));
      run_req("rnd", ra, rf, rs, $urandom, 5'($urandom_range(0, 31)), $urandom, rw);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the integer ALU.
- Consumes the ALU result as the effective address, plus rs2 store data and the RV32I load/store funct3 from execute.
- Drives a single-outstanding request/ready data-memory port, and returns aligned, sign/zero-extended load data (or a fault) to writeback.
- Detects misaligned and illegal accesses, and aborts bus transactions that exceed a timeout.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles mem_valid may stay high without mem_ready before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  execute presents an access
- req_ready  out  1  unit can accept; high only in IDLE
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data (rs2)
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_is_store  in  1  1 = store, 0 = load
- req_rd  in  5  destination register tag, carried to the response
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accept; read data valid in the same cycle
- mem_we  out  1  write enable
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_rdata  in  32  read data
- rsp_valid  out  1  one-cycle response pulse; writeback always accepts
- rsp_is_load  out  1  response belongs to a load
- rsp_rd  out  5  tag from the request
- rsp_data  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout
- rsp_addr  out  32  original byte address (trap value)

Behaviour:
- Reset (reset_n low at an edge):
  - state=IDLE.
  - mem_valid, mem_we, rsp_valid, rsp_is_load = 0.
  - mem_addr, mem_wdata, mem_be, rsp_data, rsp_rd, rsp_fault, rsp_addr = 0.
  - Timeout counter = 0.
  - Reset mid-ACCESS drops mem_valid at that edge; no response is produced.
- All outputs are registered except req_ready (= state==IDLE).
- FSM states are IDLE and ACCESS. Transitions:
  - IDLE, req_valid, funct3 illegal (011, 110, 111, or a store with 1xx): next cycle rsp_valid=1, rsp_fault=10; stay IDLE.
  - IDLE, req_valid, misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): next cycle rsp_valid=1, rsp_fault=01; stay IDLE. The illegal-funct3 check has priority over misalignment.
  - IDLE, req_valid, legal: latch the request, set mem_valid=1 and the bus fields, go to ACCESS, counter=0.
  - ACCESS, mem_ready=1: next cycle mem_valid=0, rsp_valid=1, rsp_fault=00, rsp_data=extracted load data or 0; go to IDLE.
  - ACCESS, mem_ready=0: counter++. When counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0), next cycle mem_valid=0, rsp_valid=1, rsp_fault=11; go to IDLE.
  - If mem_ready arrives in the cycle the count expires, mem_ready wins: the access completes normally.
- Bus fields hold stable while mem_valid=1.
- Latency: accept at edge T; mem_valid visible T..; with zero-wait memory (mem_ready at T+1), rsp_valid at T+2. Fault responses arrive at T+1.
- Stores:
  - mem_we=1.
  - B: mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<addr[1:0].
  - H: mem_wdata={2{wdata[15:0]}}, mem_be=4'b0011<<addr[1:0].
  - W: mem_wdata=wdata, mem_be=4'b1111.
- Loads:
  - mem_we=0, mem_be per size as for stores.
  - Shift mem_rdata right by 8*addr[1:0].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- No new request is accepted in the cycle a response is produced from ACCESS; req_ready rises the following cycle (state=IDLE).
- rsp_rd, rsp_is_load and rsp_addr are valid with every response, including faults.

Decomposition:
- lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Fault-code localparams (FAULT_NONE, FAULT_MISALIGN, FAULT_ILLEGAL, FAULT_TIMEOUT).
  - FSM state encoding (ST_IDLE, ST_ACCESS).
- Sub-module load_align: combinational rdata/addr[1:0]/funct3 -> extended 32-bit load value. Unit-testable on its own.

Test Plan:
- LB at 0x1003, zero-wait, mem_rdata=0x80FF_1234 -> rsp_valid at T+2, rsp_data=0xFFFF_FF80, rsp_fault=00, mem_be=1000.
- LHU at 0x2002, mem_rdata=0xBEEF_0000 -> rsp_data=0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
- SB at 0x3001 with wdata=0x0000_00AB -> mem_we=1, mem_addr=0x3000, mem_wdata=0xABAB_ABAB, mem_be=0010; rsp_is_load=0, rsp_data=0.
- LW at 0x4002 -> no mem_valid; rsp_valid at T+1, rsp_fault=01, rsp_addr=0x4002. funct3=011 at any address -> rsp_fault=10.
- LW with mem_ready held low, TIMEOUT_CYCLES=16 -> mem_valid high for exactly 16 cycles, then rsp_fault=11, IDLE, req_ready=1. A repeat run with mem_ready in the 16th cycle -> normal response.
- Assert reset_n=0 for one cycle during ACCESS -> mem_valid=0 and rsp_valid=0 next cycle; a new LW accepted afterwards completes normally.
